// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: access-size codes, clear-FSM states, poison pattern.
// Latency: none (package only).
// Backpressure: none (package only).
package dmem_pkg;

    // Access size codes shared by rd_size / wr_size.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Clear-FSM state encoding. It is kept as plain constants so that older
    // blocks which compare against raw bits keep working.
    typedef logic [0:0] dmem_state_t;
    localparam dmem_state_t CLEAR = 1'b0;
    localparam dmem_state_t IDLE  = 1'b1;

    // Value driven on read_data when no valid read result is present.
    // Callers truncate it to their own data width.
    function automatic logic [63:0] poison_pattern();
        return {2{32'hDEADBEEF}};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store shift/byte enables, load extract/extend, alignment check.
// Latency: purely combinational.
// Backpressure: none; flags illegal accesses through wr_ok / rd_ok and leaves acceptance to the caller.
//
// Ports:
//   wr_off, wr_size, wr_dat    store offset/size/right-aligned data
//   wr_lane_dat, wr_be, wr_ok  data moved to its byte lanes, byte enables, access legal
//   rd_off, rd_size, rd_unsigned, rd_word  load offset/size/extension mode and the raw word
//   rd_ext, rd_ok              extracted and extended load value, access legal
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]    wr_off,
    input  logic [1:0]          wr_size,
    input  logic [DATA_W-1:0]   wr_dat,
    output logic [DATA_W-1:0]   wr_lane_dat,
    output logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ok,
    input  logic [OFF_W-1:0]    rd_off,
    input  logic [1:0]          rd_size,
    input  logic                rd_unsigned,
    input  logic [DATA_W-1:0]   rd_word,
    output logic [DATA_W-1:0]   rd_ext,
    output logic                rd_ok
);

    localparam int NB    = DATA_W / 8;
    localparam int BIT_W = $clog2(DATA_W);

    // Offset must be a multiple of the access size in bytes; a dword access
    // on a 32-bit memory has no legal alignment at all.
    function automatic logic access_ok(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic [OFF_W-1:0] low_mask;
        if (size == SZ_D && DATA_W == 32) begin
            return 1'b0;
        end
        low_mask = OFF_W'((32'd1 << size) - 32'd1);
        return (off & low_mask) == '0;
    endfunction

    assign wr_ok = access_ok(wr_off, wr_size);
    assign rd_ok = access_ok(rd_off, rd_size);

    // Store steering: move the right-aligned data up to its first lane.
    always_comb begin
        logic [NB-1:0] base_be;
        base_be     = NB'((32'd1 << (32'd1 << wr_size)) - 32'd1);
        wr_be       = base_be << wr_off;
        wr_lane_dat = wr_dat << {wr_off, 3'b000};
    end

    // Load steering: bring the addressed lanes down to bit 0, then fill the
    // upper bits with the access's top bit (signed) or zero (unsigned).
    always_comb begin
        logic [DATA_W-1:0] shifted;
        int                nbits;
        logic [BIT_W-1:0]  msb;
        logic              fill;
        shifted = rd_word >> {rd_off, 3'b000};
        nbits   = 8 << rd_size;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        msb    = BIT_W'(nbits - 1);
        fill   = !rd_unsigned && shifted[msb];
        rd_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rd_ext[i] = (i < nbits) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/data_mem_sync.sv
// Data memory with synchronous byte-lane writes, registered reads and a post-reset clear walk.
// Latency: read result 1 cycle after the request; a write is visible to the read issued next cycle.
// Backpressure: none; while busy (clearing) every request is dropped, misaligned requests are rejected with a misalign pulse.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   MemRead, rd_addr, rd_size, rd_unsigned   load request
//   MemWrite, wr_addr, wr_size, write_data   store request
//   read_data, rd_valid               registered load result and its qualifier
//   busy                              clear walk in progress
//   misalign                          {wr,rd} one-cycle rejection pulse
// Build option: DMEM_WR_BYPASS_EN makes a read of the word being written return the merged new bytes;
// without it such a read returns the pre-write contents.
module data_mem_sync
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_size,
    input  logic              rd_unsigned,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_size,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [1:0]        misalign
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [DATA_W-1:0] POISON = DATA_W'(poison_pattern());

    logic [DATA_W-1:0] mem [DEPTH];

    dmem_state_t      state;
    logic [IDX_W-1:0] cnt;
    logic             idle;

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [DATA_W-1:0] wr_lane_dat;
    logic [NB-1:0]     wr_be;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_ext;
    logic              wr_acc;
    logic              rd_acc;

    assign idle   = (state == IDLE);
    assign busy   = (state == CLEAR);
    assign wr_idx = wr_addr[ADDR_W-1:OFF_W];
    assign rd_idx = rd_addr[ADDR_W-1:OFF_W];
    assign wr_acc = MemWrite && idle && wr_ok;
    assign rd_acc = MemRead && idle && rd_ok;

    dmem_lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .wr_off      (wr_addr[OFF_W-1:0]),
        .wr_size     (wr_size),
        .wr_dat      (write_data),
        .wr_lane_dat (wr_lane_dat),
        .wr_be       (wr_be),
        .wr_ok       (wr_ok),
        .rd_off      (rd_addr[OFF_W-1:0]),
        .rd_size     (rd_size),
        .rd_unsigned (rd_unsigned),
        .rd_word     (rd_word),
        .rd_ext      (rd_ext),
        .rd_ok       (rd_ok)
    );

`ifdef DMEM_WR_BYPASS_EN
    // Same-word read during a write sees the bytes being written this cycle.
    logic [DATA_W-1:0] wr_bit_mask;
    always_comb begin
        wr_bit_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wr_bit_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
        if (wr_acc && (wr_idx == rd_idx)) begin
            rd_word = (mem[rd_idx] & ~wr_bit_mask) | (wr_lane_dat & wr_bit_mask);
        end else begin
            rd_word = mem[rd_idx];
        end
    end
`else
    // Array read happens before this edge's write lands: read-old-data.
    assign rd_word = mem[rd_idx];
`endif

    // Array: the clear walk owns the write port while busy, then byte-lane stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_acc) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_idx][b*8 +: 8] <= wr_lane_dat[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Clear FSM: one word per cycle, leaves CLEAR after the last word is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == IDX_W'(DEPTH - 1)) begin
                state <= IDLE;
            end
        end
    end

    // Output registers. Requests while busy produce neither data nor flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= POISON;
            rd_valid  <= 1'b0;
            misalign  <= 2'b00;
        end else begin
            read_data <= rd_acc ? rd_ext : POISON;
            rd_valid  <= rd_acc;
            misalign  <= {MemWrite && idle && !wr_ok, MemRead && idle && !rd_ok};
        end
    end

endmodule
